// File: rtl/uart_tx_packer.sv
// Frames 32-bit words from a small FIFO into 6-byte UART frames: header, four data bytes MSB first, XOR checksum.
// Bytes are handed to the byte transmitter through a single-cycle strobe handshake.
module uart_tx_packer #(
  parameter int         FIFO_DEPTH = 4,
  parameter logic [7:0] HEADER     = 8'hA5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] in_data,
  input  logic        in_vld,
  output logic        in_rdy,
  output logic [7:0]  tx_data,
  output logic        tx_vld,
  input  logic        tx_rdy,
  output logic        busy,
  output logic [15:0] frame_cnt
);

  localparam int          AW   = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(FIFO_DEPTH);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] GUARD = 2'd2;
  localparam logic [1:0] WAIT  = 2'd3;

  logic [31:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic [31:0]   head;
  logic          push;
  logic          pop;

  logic [1:0]  state;
  logic [2:0]  idx;
  logic [31:0] word;
  logic [7:0]  chk;
  logic [7:0]  cur_byte;

  // in_rdy is held low while reset is asserted so nothing is written into a FIFO being cleared
  assign in_rdy = !rst && (count != FULL);
  assign push   = in_vld && in_rdy;
  assign pop    = (state == IDLE) && (count != '0);
  assign busy   = (state != IDLE) || (count != '0);
  assign head   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_comb begin
    cur_byte = HEADER;
    case (idx)
      3'd0:    cur_byte = HEADER;
      3'd1:    cur_byte = word[31:24];
      3'd2:    cur_byte = word[23:16];
      3'd3:    cur_byte = word[15:8];
      3'd4:    cur_byte = word[7:0];
      default: cur_byte = chk;
    endcase
  end

  // GUARD spends one cycle ignoring tx_rdy, since the transmitter drops it one cycle after the strobe
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= '0;
      word      <= '0;
      chk       <= '0;
      tx_data   <= '0;
      tx_vld    <= 1'b0;
      frame_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            word  <= head;
            chk   <= head[31:24] ^ head[23:16] ^ head[15:8] ^ head[7:0];
            idx   <= '0;
            state <= ISSUE;
          end
        end
        ISSUE: begin
          if (tx_rdy) begin
            tx_data <= cur_byte;
            tx_vld  <= 1'b1;
            state   <= GUARD;
          end
        end
        GUARD: begin
          tx_vld <= 1'b0;
          state  <= WAIT;
        end
        WAIT: begin
          if (tx_rdy) begin
            if (idx == 3'd5) begin
              frame_cnt <= frame_cnt + 16'd1;
              state     <= IDLE;
            end else begin
              idx   <= idx + 3'd1;
              state <= ISSUE;
            end
          end
        end
      endcase
    end
  end

endmodule
